// File: rtl/lwe_encrypt_stream.sv
// lwe_encrypt_stream
//   LWE encryption stage. Sums a randomly selected subset of BIG_N public-key
//   rows (DIMENSION+1 entries each, mod q), adds the scaled plaintext
//   m*(q/p) to entry 0, then streams the ciphertext out PARALLEL entries per
//   cycle. The chunk index on row feeds the decrypt stage's row input directly.
//
//   Optional build macro: LWE_ENCRYPT_NOISE_EN
//     When defined, a noise input (value < q) is latched with start and also
//     added to entry 0 during ENCODE.
//
//   Ports
//     clk, rst_n        clock, synchronous active-low reset
//     start, plaintext  begin an encryption (IDLE only); plaintext latched mod p
//     noise             (LWE_ENCRYPT_NOISE_EN only) error term, latched with start
//     pk_valid/pk_ready public-key chunk handshake; pk_ready high in ACCUM
//     pk_entry          PARALLEL lanes, lane k = entry chunk*PARALLEL+k
//     pk_select         include bit for the current row, sampled at chunk 0
//     ct_valid/ct_ready ciphertext chunk handshake
//     ct_entry, row     ciphertext chunk and its chunk index
//     busy, done        non-IDLE flag, one-cycle completion pulse
//
//   state  | meaning
//   IDLE   | waiting for start
//   ACCUM  | consuming public-key chunks, summing selected rows
//   ENCODE | one cycle: fold m*(q/p) (and noise) into entry 0
//   EMIT   | streaming ciphertext chunks to the decrypt stage
module lwe_encrypt_stream #(
  parameter int PLAINTEXT_MODULUS  = 64,
  parameter int PLAINTEXT_WIDTH    = 8,
  parameter int CIPHERTEXT_MODULUS = 1024,
  parameter int CIPHERTEXT_WIDTH   = 16,
  parameter int DIMENSION          = 3,
  parameter int BIG_N              = 30,
  parameter int PARALLEL           = 2,
  localparam int CHUNKS            = (DIMENSION + 1) / PARALLEL,
  localparam int ROW_W             = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [PLAINTEXT_WIDTH-1:0]           plaintext,
`ifdef LWE_ENCRYPT_NOISE_EN
  input  logic [CIPHERTEXT_WIDTH-1:0]          noise,
`endif
  input  logic                                 pk_valid,
  output logic                                 pk_ready,
  input  logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] pk_entry,
  input  logic                                 pk_select,
  output logic                                 ct_valid,
  input  logic                                 ct_ready,
  output logic [PARALLEL*CIPHERTEXT_WIDTH-1:0] ct_entry,
  output logic [ROW_W-1:0]                     row,
  output logic                                 busy,
  output logic                                 done
);

  localparam int ENTRIES = DIMENSION + 1;
  localparam int W       = CIPHERTEXT_WIDTH;
  localparam int WE      = W + 1;
  localparam int PW      = PLAINTEXT_WIDTH;
  localparam int RCNT_W  = (BIG_N > 1) ? $clog2(BIG_N) : 1;

  localparam logic [WE-1:0] Q_EXT = WE'(CIPHERTEXT_MODULUS);
  localparam logic [W-1:0]  DELTA = W'(CIPHERTEXT_MODULUS / PLAINTEXT_MODULUS);

  typedef enum logic [1:0] {IDLE, ACCUM, ENCODE, EMIT} state_t;

  state_t              state;
  logic [W-1:0]        acc [ENTRIES];
  logic [ROW_W-1:0]    chunk_cnt;
  logic [RCNT_W-1:0]   row_cnt;
  logic                sel_q;
  logic [PW-1:0]       m_q;
`ifdef LWE_ENCRYPT_NOISE_EN
  logic [W-1:0]        noise_q;
`endif

  logic                          sel_now;
  logic [W-1:0]                  m_delta;
  logic [W-1:0]                  enc0;
  logic [ROW_W-1:0]              next_row;
  logic [PARALLEL*W-1:0]         chunk0_enc;
  logic [PARALLEL*W-1:0]         next_chunk;

  // Operands are both < q, so one conditional subtract is enough.
  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [WE-1:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q_EXT) s = s - Q_EXT;
    return s[W-1:0];
  endfunction

  // The include bit is taken live on chunk 0 and held for the rest of the row.
  assign sel_now  = (chunk_cnt == '0) ? pk_select : sel_q;
  // m < p, so m*(q/p) < q and needs no reduction.
  assign m_delta  = W'(m_q) * DELTA;
  assign next_row = row + 1'b1;

`ifdef LWE_ENCRYPT_NOISE_EN
  assign enc0 = mod_add(mod_add(acc[0], m_delta), noise_q);
`else
  assign enc0 = mod_add(acc[0], m_delta);
`endif

  always_comb begin
    chunk0_enc = '0;
    next_chunk = '0;
    for (int k = 0; k < PARALLEL; k++) begin
      chunk0_enc[k*W +: W] = (k == 0) ? enc0 : acc[k];
    end
    for (int c = 0; c < CHUNKS; c++) begin
      if (next_row == ROW_W'(c)) begin
        for (int k = 0; k < PARALLEL; k++) begin
          next_chunk[k*W +: W] = acc[c*PARALLEL + k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int i = 0; i < ENTRIES; i++) acc[i] <= '0;
      chunk_cnt <= '0;
      row_cnt   <= '0;
      sel_q     <= 1'b0;
      m_q       <= '0;
`ifdef LWE_ENCRYPT_NOISE_EN
      noise_q   <= '0;
`endif
      pk_ready  <= 1'b0;
      ct_valid  <= 1'b0;
      ct_entry  <= '0;
      row       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < ENTRIES; i++) acc[i] <= '0;
            chunk_cnt <= '0;
            row_cnt   <= '0;
            row       <= '0;
            m_q       <= PW'(32'(plaintext) % 32'(PLAINTEXT_MODULUS));
`ifdef LWE_ENCRYPT_NOISE_EN
            noise_q   <= noise;
`endif
            pk_ready  <= 1'b1;
            busy      <= 1'b1;
            state     <= ACCUM;
          end
        end

        ACCUM: begin
          if (pk_valid) begin
            if (chunk_cnt == '0) sel_q <= pk_select;
            for (int c = 0; c < CHUNKS; c++) begin
              for (int k = 0; k < PARALLEL; k++) begin
                if (sel_now && chunk_cnt == ROW_W'(c)) begin
                  acc[c*PARALLEL + k] <= mod_add(acc[c*PARALLEL + k], pk_entry[k*W +: W]);
                end
              end
            end
            if (chunk_cnt == ROW_W'(CHUNKS - 1)) begin
              chunk_cnt <= '0;
              if (row_cnt == RCNT_W'(BIG_N - 1)) begin
                pk_ready <= 1'b0;
                state    <= ENCODE;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else begin
              chunk_cnt <= chunk_cnt + 1'b1;
            end
          end
        end

        ENCODE: begin
          acc[0]   <= enc0;
          ct_entry <= chunk0_enc;
          row      <= '0;
          ct_valid <= 1'b1;
          state    <= EMIT;
        end

        EMIT: begin
          if (ct_ready) begin
            if (row == ROW_W'(CHUNKS - 1)) begin
              ct_valid <= 1'b0;
              done     <= 1'b1;
              busy     <= 1'b0;
              row      <= '0;
              state    <= IDLE;
            end else begin
              row      <= next_row;
              ct_entry <= next_chunk;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
